// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: ibus request/response, execute redirect and decode handshake.
// dec_misalign exists only when FETCH_MISALIGN_CHECK_EN is defined.
interface fetch_unit_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        ireq_ready;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        dec_misalign;
`endif

    modport master (
`ifdef FETCH_MISALIGN_CHECK_EN
        output dec_misalign,
`endif
        output ireq_valid, ireq_addr, dec_valid, dec_instr, dec_pc,
        input  ireq_ready, iresp_valid, iresp_data, redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
`ifdef FETCH_MISALIGN_CHECK_EN
        input  dec_misalign,
`endif
        input  ireq_valid, ireq_addr, dec_valid, dec_instr, dec_pc,
        output ireq_ready, iresp_valid, iresp_data, redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one ibus fetch outstanding and buffers {pc,instr} for decode.
// FETCH_MISALIGN_CHECK_EN: a misaligned redirect delivers a flagged nop and parks fetch until the next redirect.
module fetch_unit #(
    parameter logic [63:0] PC_RESET   = 64'h8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {REQ, WAIT, DISCARD} state_t;

    state_t        state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          stall_q, stall_d;
    logic          ireq_valid_q, ireq_valid_d;
    logic [63:0]   ireq_addr_q;
    logic          accept, push, pop, nop_push, dec_valid;

    logic [63:0]   mem_pc    [FIFO_DEPTH];
    logic [31:0]   mem_instr [FIFO_DEPTH];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        stall_d  = stall_q;
        push     = 1'b0;
        pop      = 1'b0;
        nop_push = 1'b0;
        accept   = ireq_valid_q && bus.ireq_ready;
        if (bus.redirect_valid) begin
            // a response still owed by the ibus has to be swallowed in DISCARD
            if (accept || (state_q != REQ && !bus.iresp_valid)) state_d = DISCARD;
            else                                                 state_d = REQ;
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            pc_d     = bus.redirect_pc;
            stall_d  = bus.redirect_pc[1:0] != 2'b00;
            nop_push = stall_d;
            if (nop_push) begin
                wr_d  = PW'(1);
                cnt_d = (PW+1)'(1);
            end
`else
            pc_d = {bus.redirect_pc[63:2], 2'b00};
`endif
        end else begin
            pop = dec_valid && bus.dec_ready;
            case (state_q)
                REQ:     if (accept) state_d = WAIT;
                WAIT:    if (bus.iresp_valid) begin
                             push    = 1'b1;
                             pc_d    = pc_q + 64'd4;
                             state_d = REQ;
                         end
                DISCARD: if (bus.iresp_valid) state_d = REQ;
                default: state_d = REQ;
            endcase
            wr_d  = wr_q + PW'(push);
            rd_d  = rd_q + PW'(pop);
            cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        end
        // request only when the response is guaranteed a slot
        ireq_valid_d = (state_d == REQ) && (cnt_d < DEPTH_C) && !stall_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= REQ;
            pc_q         <= PC_RESET;
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            stall_q      <= 1'b0;
            ireq_valid_q <= 1'b0;
            ireq_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            stall_q      <= stall_d;
            ireq_valid_q <= ireq_valid_d;
            ireq_addr_q  <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (nop_push) begin
            mem_pc[0]    <= bus.redirect_pc;
            mem_instr[0] <= NOP;
        end else if (push) begin
            mem_pc[wr_q]    <= pc_q;
            mem_instr[wr_q] <= bus.iresp_data;
        end
    end

    assign dec_valid      = cnt_q != '0;
    assign bus.dec_valid  = dec_valid;
    assign bus.dec_pc     = dec_valid ? mem_pc[rd_q]    : '0;
    assign bus.dec_instr  = dec_valid ? mem_instr[rd_q] : '0;
    assign bus.ireq_valid = ireq_valid_q;
    assign bus.ireq_addr  = ireq_addr_q;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic mem_mis [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (nop_push)  mem_mis[0]    <= 1'b1;
        else if (push) mem_mis[wr_q] <= 1'b0;
    end

    assign bus.dec_misalign = dec_valid ? mem_mis[rd_q] : 1'b0;
`endif
endmodule
